dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 32-bit words in the backing store (power of two, 2..1024).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to response (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  reset is asynchronous and active-high.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_we  input  1  1 = write (memwrite), 0 = read.
REQ-008 SHALL have port req_addr  input  32  byte address (aluout).
REQ-009 SHALL have port req_wdata  input  32  write data (writedata).
REQ-010 SHALL have port rsp_valid  output  1  response present.
REQ-011 SHALL have port rsp_ready  input  1  initiator takes the response this cycle.
REQ-012 SHALL have port rsp_rdata  output  32  read data (readdata).
REQ-013 SHALL have port rsp_err  output  1  request was rejected; no access performed.

Function
REQ-014 SHALL implement FSM states IDLE, BUSY and RESP; req_ready = (state == IDLE), rsp_valid = (state == RESP).
REQ-015 SHALL accept a request on a rising edge with req_valid & req_ready, capture we/addr/wdata, load the counter with LATENCY-1 and enter BUSY.
REQ-016 In BUSY, SHALL decrement the counter each edge; on the edge where the counter is 0, SHALL perform the access and enter RESP, so rsp_valid rises at the LATENCY-th edge after acceptance.
REQ-017 SHALL index the word at captured addr[log2(DEPTH)+1:2]; out-of-range is captured addr >= DEPTH*4.
REQ-018 Read: SHALL register the word into rsp_rdata with rsp_err = 0.
REQ-019 Write: SHALL store wdata at the access edge; rsp_rdata = 0, rsp_err = 0.
REQ-020 Out-of-range or error request: SHALL NOT write; rsp_rdata = 0, rsp_err = 1.
REQ-021 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until an edge with rsp_ready = 1, then return to IDLE.
REQ-022 SHALL ignore req_valid outside IDLE; at least one idle cycle separates consecutive acceptances.
REQ-023 A read of a word written by the previous request SHALL return the newly written value.
REQ-024 Inputs captured at acceptance SHALL be the only ones used; req_* changes during BUSY/RESP have no effect.

Reset
REQ-025 On reset assertion, SHALL immediately enter IDLE: req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, counter = 0.
REQ-026 Reset during BUSY SHALL abort the request; a pending write SHALL NOT be committed.
REQ-027 Reset SHALL NOT clear the backing store; its contents are retained across reset and undefined at power-up.

Configuration
REQ-028 Macro DMEM_ALIGN_CHECK_EN defined: a request with captured addr[1:0] != 0 SHALL be treated as an error (REQ-020).
REQ-029 Macro DMEM_ALIGN_CHECK_EN undefined: addr[1:0] SHALL be ignored and the access proceeds on the containing word.

Verification
REQ-030 Write 0xDEADBEEF to 0x00000010 (LATENCY=2), then read 0x10 -> rsp_valid 2 edges after each acceptance; read rsp_rdata = 0xDEADBEEF, rsp_err = 0.
REQ-031 Read 0x00000100 with DEPTH=64 -> rsp_err = 1, rsp_rdata = 0; then read 0x0 -> prior contents unchanged.
REQ-032 Hold rsp_ready = 0 for 5 cycles in RESP -> rsp_valid/rsp_rdata stable; req_valid during this time is not accepted (req_ready = 0).
REQ-033 Write 0x12345678 to 0x20, assert reset one cycle after acceptance, then read 0x20 -> old value returned; outputs at reset values during reset.
REQ-034 Write to 0x00000006 -> with DMEM_ALIGN_CHECK_EN: rsp_err = 1, word 1 unchanged; without: rsp_err = 0, word 1 updated.
REQ-035 LATENCY=1 back-to-back reads with rsp_ready tied 1 -> one response every 3 cycles, no lost or duplicated responses.

Source files
------------

// File: rtl/dmem_responder.sv
// Latency-configurable single-port data-memory responder with a valid/ready request/response handshake.
// Optional DMEM_ALIGN_CHECK_EN: misaligned byte addresses are rejected as errors instead of word-truncated.
`timescale 1ns/1ps
module dmem_responder #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    logic [1:0]    state;
    logic [3:0]    cnt;
    logic          we_q;
    logic [31:2]   addr_q;
    logic [31:0]   wdata_q;
    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] idx;
    logic          oor;
    logic          bad;
    logic          access;

    assign idx    = addr_q[AW+1:2];
    assign oor    = (addr_q[31:AW+2] != '0);
    assign access = (state == BUSY) && (cnt == 4'd0);

`ifdef DMEM_ALIGN_CHECK_EN
    logic [1:0] lo_q;
    assign bad = oor | (lo_q != 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            lo_q <= 2'b00;
        else if (req_valid && req_ready)
            lo_q <= req_addr[1:0];
    end
`else
    logic unused_lo;
    assign unused_lo = &{1'b0, req_addr[1:0]};
    assign bad = oor;
`endif

    assign req_ready = (state == IDLE);
    assign rsp_valid = (state == RESP);

    // Backing store has no reset: contents survive reset, and a reset during BUSY
    // drops the state back to IDLE before the access edge so no write commits.
    always_ff @(posedge clk) begin
        if (access && we_q && !bad)
            mem[idx] <= wdata_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        we_q    <= req_we;
                        addr_q  <= req_addr[31:2];
                        wdata_q <= req_wdata;
                        cnt     <= LAT_M1;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        rsp_rdata <= (!bad && !we_q) ? mem[idx] : 32'h0;
                        rsp_err   <= bad;
                        state     <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (rsp_ready)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
